// File: rtl/spi_reg_pkg.sv
// Shared constants for the SPI register-bank target.
//   FSM state encodings, the rw-bit polarity, and the frame length helper.
package spi_reg_pkg;

  // FSM state encodings
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CMD  = 2'd1;
  localparam logic [1:0] DATA = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  // Command MSB value that selects a write
  localparam logic RW_WRITE = 1'b1;

  // Total bits in one complete frame: rw + address + data
  function automatic int unsigned FRAME_LEN(input int unsigned addr_w, input int unsigned data_w);
    return 1 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous input, with edge pulses.
//   clk, rst : system clock, async active-high reset
//   din      : asynchronous input
//   level    : synchronised level (SYNC_STAGES flops after din)
//   rise     : one-clk pulse on a synchronised 0->1 transition
//   fall     : one-clk pulse on a synchronised 1->0 transition
// The chain resets to 0, so an input already low at reset release produces
// no falling-edge pulse.
module spi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  // SYNC_STAGES synchroniser flops plus one history flop for edge detection
  logic [SYNC_STAGES:0] pipe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe <= '0;
    end else begin
      pipe <= {pipe[SYNC_STAGES-1:0], din};
    end
  end

  assign level = pipe[SYNC_STAGES-1];
  assign rise  = pipe[SYNC_STAGES-1] & ~pipe[SYNC_STAGES];
  assign fall  = ~pipe[SYNC_STAGES-1] & pipe[SYNC_STAGES];

endmodule

// File: rtl/spi_reg_bank.sv
// SPI mode-0 target with a NUM_REGS x DATA_W read/write register bank.
//   clk, rst   : system clock (>= 8x SCLK), async active-high reset
//   sclk, copi : SPI clock and controller-out data (asynchronous)
//   ncs        : SPI chip select, active low (asynchronous)
//   cipo       : target-out data, valid while cipo_oe is high
//   cipo_oe    : high during the data phase of a read frame
//   regs_o     : flat register bank, reg k = regs_o[k*DATA_W +: DATA_W]
//   wr_strobe  : one-clk pulse on each committed write
//   wr_addr    : address of the last committed write
// Frame (MSB first, sampled on sclk rise): rw (1 = write), addr, data.
module spi_reg_bank
  import spi_reg_pkg::*;
#(
  parameter int unsigned NUM_REGS    = 5,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ADDR_W      = 7,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sclk,
  input  logic                       copi,
  input  logic                       ncs,
  output logic                       cipo,
  output logic                       cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0] regs_o,
  output logic                       wr_strobe,
  output logic [ADDR_W-1:0]          wr_addr
);

  localparam int unsigned CNT_W = $clog2(FRAME_LEN(ADDR_W, DATA_W));
  localparam logic [CNT_W-1:0]  CMD_LAST  = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0]  DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [ADDR_W:0]   NUM_REGS_W = (ADDR_W + 1)'(NUM_REGS);

  logic sclk_level, sclk_rise, sclk_fall;
  logic copi_level, copi_rise, copi_fall;
  logic ncs_level, ncs_rise, ncs_fall;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk   (clk),
    .rst   (rst),
    .din   (sclk),
    .level (sclk_level),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_copi (
    .clk   (clk),
    .rst   (rst),
    .din   (copi),
    .level (copi_level),
    .rise  (copi_rise),
    .fall  (copi_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ncs (
    .clk   (clk),
    .rst   (rst),
    .din   (ncs),
    .level (ncs_level),
    .rise  (ncs_rise),
    .fall  (ncs_fall)
  );

  // Only copi's level and the sclk/ncs edges drive the FSM
  logic unused_sync;
  assign unused_sync = ^{sclk_level, ncs_level, copi_rise, copi_fall};

  logic [1:0]        state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [ADDR_W:0]   cmd_shift;
  logic [DATA_W-1:0] data_shift;
  logic [DATA_W-1:0] tx_shift;
  logic              rw;
  logic [ADDR_W-1:0] addr;

  // Shift-register values including the bit being sampled this cycle
  logic [ADDR_W:0]   cmd_next;
  logic [DATA_W-1:0] data_next;
  logic [DATA_W-1:0] tx_next;
  logic [DATA_W-1:0] rd_data;
  logic              addr_ok;

  assign cmd_next  = {cmd_shift[ADDR_W-1:0], copi_level};
  assign data_next = {data_shift[DATA_W-2:0], copi_level};
  assign tx_next   = tx_shift << 1;
  assign addr_ok   = {1'b0, addr} < NUM_REGS_W;

  // Read mux on the address being latched; out-of-range addresses read as 0
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < int'(NUM_REGS); k++) begin
      if (cmd_next[ADDR_W-1:0] == ADDR_W'(k)) begin
        rd_data = regs_o[k*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      cmd_shift  <= '0;
      data_shift <= '0;
      tx_shift   <= '0;
      rw         <= 1'b0;
      addr       <= '0;
      cipo       <= 1'b0;
      cipo_oe    <= 1'b0;
      regs_o     <= '0;
      wr_strobe  <= 1'b0;
      wr_addr    <= '0;
    end else begin
      wr_strobe <= 1'b0;
      if (ncs_rise) begin
        // Deselect aborts whatever is in flight, including a commit on this same clk
        state   <= IDLE;
        bit_cnt <= '0;
        cipo    <= 1'b0;
        cipo_oe <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (ncs_fall) begin
              state   <= CMD;
              bit_cnt <= '0;
            end
          end
          CMD: begin
            if (sclk_rise) begin
              cmd_shift <= cmd_next;
              if (bit_cnt == CMD_LAST) begin
                rw      <= cmd_next[ADDR_W];
                addr    <= cmd_next[ADDR_W-1:0];
                bit_cnt <= '0;
                state   <= DATA;
                if (cmd_next[ADDR_W] != RW_WRITE) begin
                  tx_shift <= rd_data;
                  cipo     <= rd_data[DATA_W-1];
                  cipo_oe  <= 1'b1;
                end
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
          DATA: begin
            if (sclk_rise) begin
              data_shift <= data_next;
              if (bit_cnt == DATA_LAST) begin
                state   <= DONE;
                cipo    <= 1'b0;
                cipo_oe <= 1'b0;
                if (rw == RW_WRITE && addr_ok) begin
                  for (int k = 0; k < int'(NUM_REGS); k++) begin
                    if (addr == ADDR_W'(k)) begin
                      regs_o[k*DATA_W +: DATA_W] <= data_next;
                    end
                  end
                  wr_strobe <= 1'b1;
                  wr_addr   <= addr;
                end
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else if (sclk_fall && bit_cnt != '0 && rw != RW_WRITE) begin
              // The MSB was presented on entry; the falling edge between the
              // last command bit and the first data bit must not advance it.
              tx_shift <= tx_next;
              cipo     <= tx_next[DATA_W-1];
            end
          end
          default: begin
            // DONE: sclk ignored until deselect
          end
        endcase
      end
    end
  end

endmodule
